// File: rtl/rx_fifo.sv
// Receive FIFO behind a UART receiver: one write per Out_rdy rising edge,
// first-word-fall-through read side, sticky overrun flag for dropped frames.
module rx_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             DataOut,
  input  logic                   Out_rdy,
  input  logic                   ParityError,
  input  logic                   StopBitError,
  input  logic                   Rd_en,
  input  logic                   Clr_ovr,
  output logic [7:0]             DataRd,
  output logic                   RdParityError,
  output logic                   RdStopBitError,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Almost_full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [9:0]    mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          outRdy_q;
  logic          overrun_q, overrun_d;

  logic          writeEvent;
  logic          pop;
  logic          push;
  logic          dropFrame;
  logic          isEmpty;
  logic          isFull;
  logic [9:0]    head;

  // Pointers carry an extra wrap bit so equal low bits distinguish empty from full.
  assign isEmpty    = (wrPtr_q == rdPtr_q);
  assign isFull     = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign writeEvent = Out_rdy & ~outRdy_q;
  assign pop        = Rd_en & ~isEmpty;
  assign push       = writeEvent & (~isFull | pop);
  assign dropFrame  = writeEvent & isFull & ~pop;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    overrun_d = overrun_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (dropFrame) begin
      overrun_d = 1'b1;
    end else if (Clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      outRdy_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      outRdy_q  <= Out_rdy;
      overrun_q <= overrun_d;
    end
  end

  // Storage is not reset; an empty FIFO masks whatever the array holds.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= {StopBitError, ParityError, DataOut};
    end
  end

  assign head           = mem_q[rdPtr_q[AW-1:0]];
  assign DataRd         = isEmpty ? 8'h00 : head[7:0];
  assign RdParityError  = isEmpty ? 1'b0 : head[8];
  assign RdStopBitError = isEmpty ? 1'b0 : head[9];

  assign Empty       = isEmpty;
  assign Full        = isFull;
  assign Count       = wrPtr_q - rdPtr_q;
  assign Almost_full = (32'(Count) >= AF_LEVEL);
  assign Overrun     = overrun_q;

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: directed vector table, corner-case
// sequences and a randomized run compared against a queue-based model.
module tb_rx_fifo;

  localparam int DEPTH    = 8;
  localparam int AF_LEVEL = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] DataOut = 8'h00;
  logic       Out_rdy = 1'b0;
  logic       ParityError = 1'b0;
  logic       StopBitError = 1'b0;
  logic       Rd_en = 1'b0;
  logic       Clr_ovr = 1'b0;
  logic [7:0] DataRd;
  logic       RdParityError;
  logic       RdStopBitError;
  logic       Empty;
  logic       Full;
  logic       Almost_full;
  logic [3:0] Count;
  logic       Overrun;

  rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .DataOut(DataOut), .Out_rdy(Out_rdy),
    .ParityError(ParityError), .StopBitError(StopBitError), .Rd_en(Rd_en),
    .Clr_ovr(Clr_ovr), .DataRd(DataRd), .RdParityError(RdParityError),
    .RdStopBitError(RdStopBitError), .Empty(Empty), .Full(Full),
    .Almost_full(Almost_full), .Count(Count), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: a plain queue of {stop, parity, data} frames.
  logic [9:0] modelQ[$];
  logic       modelPrevRdy = 1'b0;
  logic       modelOvr = 1'b0;

  typedef struct {
    logic       outRdy;
    logic [7:0] data;
    logic       pe;
    logic       se;
    logic       rdEn;
    logic       clr;
    int         expCount;
    logic       expEmpty;
    logic [7:0] expData;
    logic       expPe;
    logic       expSe;
  } vec_t;

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelPrevRdy = 1'b0;
    modelOvr = 1'b0;
  endtask

  task automatic modelStep(input logic o, input logic [7:0] d, input logic p,
                           input logic s, input logic r, input logic c);
    bit we, popOk, drop;
    logic [9:0] dummy;
    we = o && !modelPrevRdy;
    modelPrevRdy = o;
    popOk = r && (modelQ.size() > 0);
    drop = we && (modelQ.size() == DEPTH) && !popOk;
    if (popOk) dummy = modelQ.pop_front();
    if (we && !drop) modelQ.push_back({s, p, d});
    if (drop) modelOvr = 1'b1;
    else if (c) modelOvr = 1'b0;
  endtask

  task automatic applyStimulus(input logic o, input logic [7:0] d, input logic p,
                               input logic s, input logic r, input logic c);
    Out_rdy = o; DataOut = d; ParityError = p; StopBitError = s; Rd_en = r; Clr_ovr = c;
    modelStep(o, d, p, s, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int sz;
    logic [9:0] h;
    sz = modelQ.size();
    h = (sz > 0) ? modelQ[0] : 10'h000;
    checkVal({tag, "_count"}, int'(Count), sz);
    checkVal({tag, "_empty"}, int'(Empty), int'(sz == 0));
    checkVal({tag, "_full"}, int'(Full), int'(sz == DEPTH));
    checkVal({tag, "_afull"}, int'(Almost_full), int'(sz >= AF_LEVEL));
    checkVal({tag, "_ovr"}, int'(Overrun), int'(modelOvr));
    checkVal({tag, "_data"}, int'(DataRd), int'(h[7:0]));
    checkVal({tag, "_pe"}, int'(RdParityError), int'(h[8]));
    checkVal({tag, "_se"}, int'(RdStopBitError), int'(h[9]));
  endtask

  task automatic writeFrame(input logic [7:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popExpect(input string name, input logic [7:0] d);
    checkVal(name, int'(DataRd), int'(d));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vec_t vecs[13];
    int wrPct, rdPct;
    logic o, r, c;

    vecs[0]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h4D, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h4D, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hB3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'hB3, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0, 1'b0};

    #1;
    checkVal("reset_empty", int'(Empty), 1);
    checkVal("reset_count", int'(Count), 0);
    checkVal("reset_full", int'(Full), 0);
    checkVal("reset_ovr", int'(Overrun), 0);
    checkVal("reset_data", int'(DataRd), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].outRdy, vecs[i].data, vecs[i].pe, vecs[i].se,
                    vecs[i].rdEn, vecs[i].clr);
      checkVal($sformatf("vec%0d_count", i), int'(Count), vecs[i].expCount);
      checkVal($sformatf("vec%0d_empty", i), int'(Empty), int'(vecs[i].expEmpty));
      checkVal($sformatf("vec%0d_data", i), int'(DataRd), int'(vecs[i].expData));
      checkVal($sformatf("vec%0d_pe", i), int'(RdParityError), int'(vecs[i].expPe));
      checkVal($sformatf("vec%0d_se", i), int'(RdStopBitError), int'(vecs[i].expSe));
    end

    // Out_rdy already high as reset releases: first edge is a write.
    Out_rdy = 1'b1; DataOut = 8'h77; Rd_en = 1'b0;
    rst = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("rdyAtReset_count", int'(Count), 1);
    checkVal("rdyAtReset_data", int'(DataRd), 8'h77);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("rdyHeld_count", int'(Count), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    popExpect("rdyAtReset_pop", 8'h77);
    checkVal("rdyAtReset_empty", int'(Empty), 1);

    // Fill past full, drain in order, then reset asynchronously at Count=5.
    for (int i = 1; i <= 8; i++) writeFrame(8'(i));
    checkVal("fill8_full", int'(Full), 1);
    checkVal("fill8_count", int'(Count), 8);
    checkVal("fill8_afull", int'(Almost_full), 1);
    checkVal("fill8_ovr", int'(Overrun), 0);
    writeFrame(8'h09);
    checkVal("fill9_ovr", int'(Overrun), 1);
    checkVal("fill9_count", int'(Count), 8);
    for (int i = 1; i <= 8; i++) popExpect($sformatf("drain_%0d", i), 8'(i));
    checkVal("drain_empty", int'(Empty), 1);
    checkVal("drain_ovrSticky", int'(Overrun), 1);
    for (int i = 1; i <= 5; i++) writeFrame(8'(8'h20 + i));
    checkVal("five_count", int'(Count), 5);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkVal("asyncRst_empty", int'(Empty), 1);
    checkVal("asyncRst_count", int'(Count), 0);
    checkVal("asyncRst_ovr", int'(Overrun), 0);
    checkVal("asyncRst_full", int'(Full), 0);
    checkVal("asyncRst_data", int'(DataRd), 0);
    Out_rdy = 1'b0; Rd_en = 1'b0; Clr_ovr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Overrun set/clear priority, then write+pop while full.
    for (int i = 0; i < 8; i++) writeFrame(8'(8'h10 + i));
    writeFrame(8'hEE);
    checkVal("ovrSet", int'(Overrun), 1);
    applyStimulus(1'b1, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("ovrSetWins", int'(Overrun), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("ovrCleared", int'(Overrun), 0);
    checkVal("fullHead", int'(DataRd), 8'h10);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
    checkVal("fullWrPop_ovr", int'(Overrun), 0);
    checkVal("fullWrPop_count", int'(Count), 8);
    checkVal("fullWrPop_full", int'(Full), 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) popExpect($sformatf("fullOrder_%0d", i), 8'(8'h10 + i));
    popExpect("fullOrder_last", 8'hAA);
    checkVal("fullOrder_empty", int'(Empty), 1);

    // Randomized phases: write-heavy, balanced, read-heavy.
    for (int ph = 0; ph < 3; ph++) begin
      wrPct = 50;
      rdPct = (ph == 0) ? 10 : ((ph == 1) ? 25 : 60);
      for (int n = 0; n < 150; n++) begin
        o = ($urandom_range(0, 99) < wrPct);
        r = ($urandom_range(0, 99) < rdPct);
        c = ($urandom_range(0, 99) < 8);
        applyStimulus(o, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), r, c);
        checkOutput($sformatf("rnd%0d_%0d", ph, n));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 The module SHALL take parameter DEPTH, default 8, meaning the number of stored frames; it must be a power of two and at least 4.
REQ-002 The module SHALL take parameter AF_LEVEL, default 6, meaning the Count value at or above which Almost_full asserts.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock (the baud_clock domain of the receiver).
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port DataOut, input, 8 bits: the received byte from the upstream receiver.
REQ-006 The module SHALL have port Out_rdy, input, 1 bit: receiver frame-valid level (may stay high for more than one cycle).
REQ-007 The module SHALL have port ParityError, input, 1 bit: parity flag for the current frame.
REQ-008 The module SHALL have port StopBitError, input, 1 bit: stop-bit flag for the current frame.
REQ-009 The module SHALL have port Rd_en, input, 1 bit: consumer pop request.
REQ-010 The module SHALL have port Clr_ovr, input, 1 bit: clears the sticky Overrun flag.
REQ-011 The module SHALL have port DataRd, output, 8 bits: the head byte (first-word-fall-through).
REQ-012 The module SHALL have ports RdParityError and RdStopBitError, output, 1 bit each: the head frame's error flags.
REQ-013 The module SHALL have ports Empty, Full and Almost_full, output, 1 bit each: occupancy flags.
REQ-014 The module SHALL have port Count, output, log2(DEPTH)+1 bits: the number of stored entries.
REQ-015 The module SHALL have port Overrun, output, 1 bit: sticky flag for a dropped frame.

Function
REQ-016 Each entry SHALL be 10 bits: {StopBitError, ParityError, DataOut}.
REQ-017 A write event SHALL be the rising edge of Out_rdy (Out_rdy high this cycle, registered Out_rdy low the previous cycle), giving exactly one write per frame regardless of pulse length.
REQ-018 On a write event with Full=0, the entry SHALL be stored at wr_ptr and wr_ptr SHALL increment.
REQ-019 Pointers SHALL be log2(DEPTH)+1 bits, with the MSB as a wrap bit: Empty when pointers are equal; Full when the low bits are equal and the MSBs differ.
REQ-020 A pop SHALL occur when Rd_en=1 and Empty=0; rd_ptr increments, and Rd_en while Empty=1 SHALL be ignored with no pointer change.
REQ-021 DataRd, RdParityError and RdStopBitError SHALL reflect the entry at rd_ptr combinationally whenever Empty=0, and SHALL be 0 when Empty=1.
REQ-022 Count, Empty, Full and Almost_full SHALL update on the clock edge following the write or pop, which is 1-cycle latency from the write event to Empty deasserting.
REQ-023 Simultaneous write and pop with 0 < Count < DEPTH SHALL perform both operations and leave Count unchanged.
REQ-024 Simultaneous write and pop at Full SHALL perform both operations with no Overrun, and Full SHALL stay 1.
REQ-025 Simultaneous write and pop at Empty SHALL accept the write, ignore the pop, and set Count to 1.
REQ-026 A write event at Full with no pop SHALL drop the frame, leave the pointers unchanged, and set Overrun=1.
REQ-027 Overrun SHALL hold until Clr_ovr=1; if Clr_ovr and a new overrun occur in the same cycle, the set SHALL win.
REQ-028 Almost_full SHALL equal (Count >= AF_LEVEL).
REQ-029 Pointer wrap SHALL be modulo 2*DEPTH and SHALL require no special handling.

Reset
REQ-030 While rst=1, asynchronously: wr_ptr=0, rd_ptr=0, Count=0, Empty=1, Full=0, Almost_full=0, Overrun=0, the registered Out_rdy=0, and the data/flag outputs=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-032 If Out_rdy is already high when rst deasserts, that SHALL count as a write event on the first clock edge.

Verification
REQ-033 Write 0x4D with Out_rdy held high for 5 cycles -> Count=1, DataRd=0x4D, and no second write.
REQ-034 Write 0xB3 with ParityError=1, then pop -> RdParityError=1 with DataRd=0xB3 before the pop, and Empty=1 after it.
REQ-035 Write 9 frames 0x01..0x09 with DEPTH=8 and no reads -> Full=1 after the 8th and Overrun=1 after the 9th; pops return 0x01..0x08 in order.
REQ-036 Fill to Full, then a write and a pop in the same cycle -> Overrun=0, Count=8, and the new byte is read last.
REQ-037 Perform 20 write/pop pairs through wrap-around -> data order is preserved, Almost_full is 1 exactly when Count>=6, and Rd_en on Empty changes nothing.
REQ-038 Assert rst mid-stream with Count=5 -> Empty=1, Count=0 and Overrun=0 immediately, without waiting for a clock edge.
